// File: rtl/serial_tx_pkg.sv
// Shared types and default constants for the serial frame transmitter.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_PAR,
    S_GAP
  } tx_state_t;

  localparam logic [2:0] DEF_PREAMBLE   = 3'b101;
  localparam int         DEF_BIT_CYCLES = 4;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: tick is high in the last clock of every BIT_CYCLES-clock period.
module serial_bit_timer
  import serial_tx_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // restart aligns the period with the first preamble bit
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: preamble (MSB-first), data (LSB-first), optional even
// parity and idle gap, each bit held BIT_CYCLES clocks; all outputs registered.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int               DATA_W     = 8,
  parameter int               PRE_W      = 3,
  parameter logic [PRE_W-1:0] PREAMBLE   = PRE_W'(DEF_PREAMBLE),
  parameter int               PARITY_EN  = 1,
  parameter int               GAP_BITS   = 1,
  parameter int               BIT_CYCLES = DEF_BIT_CYCLES,
  parameter logic             IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              done
);

  localparam int MAX_A   = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int MAX_CNT = (MAX_A > GAP_BITS) ? MAX_A : GAP_BITS;
  localparam int IW      = $clog2(MAX_CNT + 1);
  localparam int FRAME   = (PRE_W + DATA_W + PARITY_EN + GAP_BITS) * BIT_CYCLES;
  localparam int FW      = $clog2(FRAME + 1);

  if (DATA_W < 1)     begin : g_chk_data_w $error("DATA_W must be >= 1");     end
  if (PRE_W < 1)      begin : g_chk_pre_w  $error("PRE_W must be >= 1");      end
  if (GAP_BITS < 1)   begin : g_chk_gap    $error("GAP_BITS must be >= 1");   end
  if (BIT_CYCLES < 1) begin : g_chk_bc     $error("BIT_CYCLES must be >= 1"); end

  tx_state_t         r_state, w_state_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic [FW-1:0]     r_left, w_left_nxt;
  logic [DATA_W-1:0] r_sh, w_sh_nxt;
  logic [PRE_W-1:0]  r_pre, w_pre_nxt;
  logic              r_par, w_par_nxt;
  logic              r_bit, r_active, r_done, r_ready;
  logic              w_bit_nxt, w_active_nxt;
  logic              w_accept, w_tick;

  assign w_accept = in_valid && r_ready;

  serial_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (w_accept),
    .tick    (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_sh_nxt    = r_sh;
    w_pre_nxt   = r_pre;
    w_par_nxt   = r_par;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_PRE;
          w_idx_nxt   = '0;
          w_sh_nxt    = in_data;
          w_pre_nxt   = PREAMBLE;
          w_par_nxt   = ^in_data;
        end
      end
      S_PRE: begin
        if (w_tick) begin
          w_pre_nxt = r_pre << 1;
          if (r_idx == IW'(PRE_W - 1)) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_sh_nxt = r_sh >> 1;
          if (r_idx == IW'(DATA_W - 1)) begin
            w_state_nxt = (PARITY_EN != 0) ? S_PAR : S_GAP;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (w_tick) begin
          w_state_nxt = S_GAP;
          w_idx_nxt   = '0;
        end
      end
      S_GAP: begin
        if (w_tick) begin
          if (r_idx == IW'(GAP_BITS - 1)) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Line level and activity are derived from the upcoming state so they register in step with it
  always_comb begin
    w_bit_nxt    = IDLE_LEVEL;
    w_active_nxt = 1'b0;
    case (w_state_nxt)
      S_PRE:   begin w_bit_nxt = w_pre_nxt[PRE_W-1]; w_active_nxt = 1'b1; end
      S_DATA:  begin w_bit_nxt = w_sh_nxt[0];        w_active_nxt = 1'b1; end
      S_PAR:   begin w_bit_nxt = w_par_nxt;          w_active_nxt = 1'b1; end
      default: begin w_bit_nxt = IDLE_LEVEL;         w_active_nxt = 1'b0; end
    endcase
  end

  // Frame-clock countdown lets done register one clock ahead of the final gap clock
  always_comb begin
    w_left_nxt = r_left;
    if (w_accept) begin
      w_left_nxt = FW'(FRAME - 1);
    end else if (r_left != '0) begin
      w_left_nxt = r_left - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_left   <= '0;
      r_bit    <= IDLE_LEVEL;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_left   <= w_left_nxt;
      r_bit    <= w_bit_nxt;
      r_active <= w_active_nxt;
      r_done   <= (r_left == FW'(1));
      r_ready  <= (w_state_nxt == S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    r_sh  <= w_sh_nxt;
    r_pre <= w_pre_nxt;
    r_par <= w_par_nxt;
  end

  assign in_ready  = r_ready;
  assign tx_bit    = r_bit;
  assign tx_active = r_active;
  assign done      = r_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: three configurations (default, no parity, one clock per bit)
// checked cycle by cycle against a frame model, plus a downstream "101" detector comparison.
module tb_serial_pattern_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid    [3];
  logic [7:0] in_data     [3];
  logic       in_ready_w  [3];
  logic       tx_bit_w    [3];
  logic       tx_active_w [3];
  logic       done_w      [3];

  int n_cmp = 0;
  int n_err = 0;
  int det_dut = 0;
  int det_ref = 0;
  logic [2:0] win_dut = 3'b000;
  logic [2:0] win_ref = 3'b000;

  serial_pattern_tx #(.PARITY_EN(1), .BIT_CYCLES(4)) u_def (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready_w[0]), .tx_bit(tx_bit_w[0]), .tx_active(tx_active_w[0]), .done(done_w[0]));

  serial_pattern_tx #(.PARITY_EN(0), .BIT_CYCLES(4)) u_nopar (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready_w[1]), .tx_bit(tx_bit_w[1]), .tx_active(tx_active_w[1]), .done(done_w[1]));

  serial_pattern_tx #(.PARITY_EN(1), .BIT_CYCLES(1)) u_fast (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_data(in_data[2]),
    .in_ready(in_ready_w[2]), .tx_bit(tx_bit_w[2]), .tx_active(tx_active_w[2]), .done(done_w[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bc_of(input int u);
    return (u == 2) ? 1 : 4;
  endfunction

  function automatic int pe_of(input int u);
    return (u == 1) ? 0 : 1;
  endfunction

  function automatic int frame_len(input int u);
    return (3 + 8 + pe_of(u) + 1) * bc_of(u);
  endfunction

  // Expected {in_ready, done, tx_active, tx_bit} in the k-th cycle after accepting d
  function automatic logic [3:0] exp_out(input int u, input logic [7:0] d, input int k);
    logic [2:0] pre;
    int f, pos, pe;
    logic b, act;
    pre = 3'b101;
    pe  = pe_of(u);
    f   = frame_len(u);
    if (k > f) return 4'b1000;
    pos = (k - 1) / bc_of(u);
    b   = 1'b0;
    act = 1'b0;
    if (pos < 3) begin
      b = pre[2 - pos]; act = 1'b1;
    end else if (pos < 11) begin
      b = d[pos - 3]; act = 1'b1;
    end else if (pe == 1 && pos == 11) begin
      b = ^d; act = 1'b1;
    end
    return {1'b0, (k == f), act, b};
  endfunction

  function automatic logic [3:0] obs(input int u);
    return {in_ready_w[u], done_w[u], tx_active_w[u], tx_bit_w[u]};
  endfunction

  task automatic send(input int u, input logic [7:0] d, input logic nv, input logic [7:0] nd,
                      input bit track);
    int f, t;
    logic [3:0] e;
    f = frame_len(u);
    t = 0;
    while (!in_ready_w[u] && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("ready_before_accept u%0d", u), {31'd0, in_ready_w[u]}, 32'd1);
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    @(posedge clk);
    for (int k = 1; k <= f + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid[u] = nv;
        in_data[u]  = nd;
      end
      e = exp_out(u, d, k);
      chk($sformatf("frame u%0d d=%02h k=%0d", u, d, k), {28'd0, obs(u)}, {28'd0, e});
      if (track) begin
        win_dut = {win_dut[1:0], tx_bit_w[u]};
        win_ref = {win_ref[1:0], e[0]};
        if (win_dut == 3'b101) det_dut++;
        if (win_ref == 3'b101) det_ref++;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    logic [3:0] e;
    reset = 1'b1;
    for (int u = 0; u < 3; u++) begin
      in_valid[u] = 1'b0;
      in_data[u]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++)
      chk($sformatf("reset_state u%0d", u), {28'd0, obs(u)}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 3; u++)
      chk($sformatf("idle_after_reset u%0d", u), {28'd0, obs(u)}, 32'h8);

    send(0, 8'hA5, 1'b0, 8'($urandom), 1'b0);
    send(0, 8'h01, 1'b0, 8'($urandom), 1'b0);
    send(1, 8'h01, 1'b0, 8'($urandom), 1'b0);
    send(2, 8'hFF, 1'b1, 8'h5A, 1'b0);
    send(2, 8'h5A, 1'b0, 8'($urandom), 1'b0);
    send(0, 8'h3C, 1'b1, 8'hC3, 1'b0);
    send(0, 8'hC3, 1'b0, 8'($urandom), 1'b0);

    // abort a frame with reset in the middle of the data bits
    w = 8'($urandom);
    in_valid[0] = 1'b1;
    in_data[0]  = w;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) in_valid[0] = 1'b0;
      e = exp_out(0, w, k);
      chk($sformatf("pre_abort k=%0d", k), {28'd0, obs(0)}, {28'd0, e});
    end
    reset = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 3; u++)
      chk($sformatf("abort_reset_cycle u%0d", u), {28'd0, obs(u)}, 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      chk($sformatf("post_abort k=%0d", k), {28'd0, obs(0)}, 32'h8);
    end

    for (int i = 0; i < 1000; i++)
      send(2, 8'($urandom), 1'($urandom), 8'($urandom), 1'b1);
    for (int i = 0; i < 60; i++)
      send(0, 8'($urandom), 1'($urandom), 8'($urandom), 1'b0);
    for (int i = 0; i < 40; i++)
      send(1, 8'($urandom), 1'($urandom), 8'($urandom), 1'b0);

    chk("detector_101_count", det_dut, det_ref);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
